// File: rtl/maxpool2_relu.sv
// rtl/maxpool2_relu.sv - 2x2 max-pool with optional ReLU over three conv2 channels
//
// Purpose: pools a raster-order feature map (WIDTH x HEIGHT, three channels
// in lockstep) with non-overlapping 2x2 windows. The top row of each window
// is reduced into a half-width line buffer. The bottom row finishes the
// window, and the result is registered one cycle after its bottom-right
// pixel is accepted.
// Optional feature: define MAXPOOL2_RELU_EN to clamp negative window results to 0.
//
// Ports:
//   clk                          - single clock, rising edge
//   rst                          - asynchronous active-high reset
//   valid_in                     - qualifies one pixel per channel this cycle
//   conv2_out_1..3  [DATA_BITS]  - signed input pixels, raster order
//   max_value_1..3  [DATA_BITS]  - pooled (and optionally rectified) results
//   valid_out_relu               - one-cycle pulse qualifying max_value_1..3
module maxpool2_relu #(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] conv2_out_1,
  input  logic [DATA_BITS-1:0] conv2_out_2,
  input  logic [DATA_BITS-1:0] conv2_out_3,
  output logic [DATA_BITS-1:0] max_value_1,
  output logic [DATA_BITS-1:0] max_value_2,
  output logic [DATA_BITS-1:0] max_value_3,
  output logic                 valid_out_relu
);

  localparam int HALF_W = WIDTH / 2;
  localparam int CW     = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
  localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  typedef logic signed [DATA_BITS-1:0] sample_t;

  sample_t pix [3];

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  sample_t       hold_q [3];
  sample_t       hold_d [3];
  sample_t       lb_q   [3][HALF_W];
  sample_t       lb_d   [3][HALF_W];
  sample_t       max_q  [3];
  sample_t       max_d  [3];
  logic          valid_q, valid_d;
  logic [LW-1:0] lb_idx;

  assign pix[0] = conv2_out_1;
  assign pix[1] = conv2_out_2;
  assign pix[2] = conv2_out_3;

  // Each column pair shares one line-buffer slot.
  assign lb_idx = LW'(col_q >> 1);

  // Signed maximum; on a tie both operands are equal, so either is correct.
  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a >= b) ? a : b;
  endfunction

  function automatic sample_t act(input sample_t v);
`ifdef MAXPOOL2_RELU_EN
    return v[DATA_BITS-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    lb_d    = lb_q;
    max_d   = max_q;
    valid_d = 1'b0;
    if (valid_in) begin
      // Both counters wrap, so back-to-back frames need no idle cycle.
      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      for (int c = 0; c < 3; c++) begin
        case ({row_q[0], col_q[0]})
          2'b00:   hold_d[c] = pix[c];
          2'b01:   lb_d[c][lb_idx] = smax(hold_q[c], pix[c]);
          2'b10:   hold_d[c] = smax(lb_q[c][lb_idx], pix[c]);
          default: max_d[c] = act(smax(hold_q[c], pix[c]));
        endcase
      end
      valid_d = row_q[0] & col_q[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int c = 0; c < 3; c++) begin
        hold_q[c] <= '0;
        max_q[c]  <= '0;
        for (int i = 0; i < HALF_W; i++) begin
          lb_q[c][i] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
      lb_q    <= lb_d;
      max_q   <= max_d;
    end
  end

  assign max_value_1    = max_q[0];
  assign max_value_2    = max_q[1];
  assign max_value_3    = max_q[2];
  assign valid_out_relu = valid_q;

endmodule

// File: tb/tb_maxpool2_relu.sv
// tb/tb_maxpool2_relu.sv - directed self-checking bench for maxpool2_relu
module tb_maxpool2_relu;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DB = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic [DB-1:0] c1 = '0;
  logic [DB-1:0] c2 = '0;
  logic [DB-1:0] c3 = '0;
  logic [DB-1:0] max_value_1;
  logic [DB-1:0] max_value_2;
  logic [DB-1:0] max_value_3;
  logic          valid_out_relu;

  int tests  = 0;
  int fails  = 0;
  int pulses = 0;

  logic signed [DB-1:0] f1 [W*H];
  logic signed [DB-1:0] f2 [W*H];
  logic signed [DB-1:0] f3 [W*H];
  logic [DB-1:0] last1 = '0;
  logic [DB-1:0] last2 = '0;
  logic [DB-1:0] last3 = '0;
  bit ramp_hand   = 1'b0;
  bit const3_hand = 1'b0;

  maxpool2_relu #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .conv2_out_1    (c1),
    .conv2_out_2    (c2),
    .conv2_out_3    (c3),
    .max_value_1    (max_value_1),
    .max_value_2    (max_value_2),
    .max_value_3    (max_value_3),
    .valid_out_relu (valid_out_relu)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [DB-1:0] smax2(input logic signed [DB-1:0] a, input logic signed [DB-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DB-1:0] act(input logic signed [DB-1:0] v);
`ifdef MAXPOOL2_RELU_EN
    return v[DB-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check_outputs(input logic exp_valid, input string tag);
    if (valid_out_relu === 1'b1) pulses++;
    check({tag, "_valid"}, {11'b0, valid_out_relu}, {11'b0, exp_valid});
    check({tag, "_m1"}, max_value_1, last1);
    check({tag, "_m2"}, max_value_2, last2);
    check({tag, "_m3"}, max_value_3, last3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      @(posedge clk);
      #1;
      check_outputs(1'b0, "idle");
    end
  endtask

  task automatic send(input int idx);
    int  r;
    int  c;
    int  b;
    bit  win;
    r = idx / W;
    c = idx % W;
    win = (r % 2 == 1) && (c % 2 == 1);
    @(negedge clk);
    valid_in = 1'b1;
    c1 = f1[idx];
    c2 = f2[idx];
    c3 = f3[idx];
    @(posedge clk);
    #1;
    if (win) begin
      b = idx - W - 1;
      last1 = act(smax2(smax2(f1[b], f1[b+1]), smax2(f1[idx-1], f1[idx])));
      last2 = act(smax2(smax2(f2[b], f2[b+1]), smax2(f2[idx-1], f2[idx])));
      last3 = act(smax2(smax2(f3[b], f3[b+1]), smax2(f3[idx-1], f3[idx])));
    end
    check_outputs(win, "pix");
    if (win && ramp_hand) begin
      check("ramp_ch1_hand", max_value_1, DB'(r * 8 + c));
      check("neg_ch2_hand", max_value_2, act(DB'(-((r - 1) * 8 + (c - 1)))));
    end
    if (win && const3_hand) check("const_ch3_hand", max_value_3, 12'h7FF);
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      if (gaps) idle(1);
      if (gaps && i == 36) idle(50);
      send(i);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < W * H; i++) begin
      int v;
      v = (i * 37) % 200 - 100;
      f1[i] = DB'(i);
      f2[i] = DB'(-i);
      f3[i] = DB'(v);
    end
  endtask

  initial begin
    // Reset with valid_in held high: the pixel must be ignored.
    #2;
    valid_in = 1'b1;
    c1 = 12'h123;
    c2 = 12'h456;
    c3 = 12'h789;
    rst = 1'b1;
    #1;
    check_outputs(1'b0, "rst_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_outputs(1'b0, "rst_hold");
    end
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b0;
    idle(100);

    // Ramp / negative frame, continuous valid.
    fill_ramp();
    ramp_hand = 1'b1;
    pulses = 0;
    send_frame(1'b0);
    check("ramp_pulses", DB'(pulses), 12'd16);

    // Same frame with alternate-cycle gaps plus a long mid-row gap.
    idle(3);
    pulses = 0;
    send_frame(1'b1);
    check("gap_pulses", DB'(pulses), 12'd16);

    // Mid-frame reset after 20 pixels, then a clean frame.
    idle(2);
    for (int i = 0; i < 20; i++) send(i);
    #2;
    rst = 1'b1;
    last1 = '0;
    last2 = '0;
    last3 = '0;
    #1;
    check_outputs(1'b0, "midrst_async");
    @(posedge clk);
    #1;
    check_outputs(1'b0, "midrst_hold");
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b0;
    pulses = 0;
    send_frame(1'b0);
    check("midrst_pulses", DB'(pulses), 12'd16);

    // Two frames back to back; the second carries a constant on channel 3.
    idle(2);
    pulses = 0;
    send_frame(1'b0);
    for (int i = 0; i < W * H; i++) f3[i] = 12'h7FF;
    const3_hand = 1'b1;
    send_frame(1'b0);
    check("b2b_pulses", DB'(pulses), 12'd32);
    const3_hand = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
